na_conf_wbm: RTL and testbench

Wishbone classic master that issues single 32-bit read/write accesses into a tile's network-adapter configuration register space on behalf of a simple valid/ready request source, such as a debug processor or a management unit. It is the initiator counterpart of the network-adapter configuration slave. Each request becomes one Wishbone cycle, with bounded retry on `rty`, and returns one response carrying data and a status code.

---
 rtl/na_conf_wbm.sv | 159 +++++++++++++++
 tb/tb_na_conf_wbm.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/na_conf_wbm.sv
// na_conf_wbm: Wishbone classic master for tile NA config space.
// Optional watchdog enabled by defining NA_CONF_WBM_TIMEOUT_EN.
module na_conf_wbm #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_RETRY = 3,
  parameter int          TIMEOUT   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [1:0]  resp_status,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RETRY,
    RESP
  } state_t;

  state_t      state;
  state_t      state_n;
  logic        we_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  retry_cnt;
  logic [31:0] rdata_q;
  logic [1:0]  status_q;

  logic        load;
  logic        retry_inc;
  logic        fin;
  logic [1:0]  fin_status;
  logic [31:0] fin_data;
  logic        timeout;

`ifdef NA_CONF_WBM_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Watchdog: zero outside BUS, counts every cycle spent in BUS.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == BUS) begin
      wd_cnt <= wd_cnt + 16'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign timeout = (wd_cnt == 16'(TIMEOUT - 1));
`else
  // No watchdog built: BUS waits for a termination forever.
  assign timeout = (TIMEOUT < 0);
`endif

  // Next state and termination decode; err beats ack beats rty.
  always_comb begin
    state_n    = state;
    load       = 1'b0;
    retry_inc  = 1'b0;
    fin        = 1'b0;
    fin_status = 2'b00;
    fin_data   = '0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          load    = 1'b1;
          state_n = BUS;
        end
      end
      BUS: begin
        if (wbm_err_i) begin
          fin        = 1'b1;
          fin_status = 2'b01;
        end else if (wbm_ack_i) begin
          fin      = 1'b1;
          fin_data = we_q ? 32'h0 : wbm_dat_i;
        end else if (wbm_rty_i) begin
          if (retry_cnt == 4'(MAX_RETRY)) begin
            fin        = 1'b1;
            fin_status = 2'b10;
          end else begin
            retry_inc = 1'b1;
            state_n   = RETRY;
          end
        end else if (timeout) begin
          fin        = 1'b1;
          fin_status = 2'b11;
        end
        if (fin) state_n = RESP;
      end
      RETRY: state_n = BUS;
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, latched request and held response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      retry_cnt <= '0;
      rdata_q   <= '0;
      status_q  <= 2'b00;
    end else begin
      state <= state_n;
      if (load) begin
        we_q      <= req_we;
        adr_q     <= {BASE_ADDR[31:16], req_addr & 16'hfffc};
        dat_q     <= req_we ? req_data : 32'h0;
        retry_cnt <= '0;
      end
      if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
      if (fin) begin
        rdata_q  <= fin_data;
        status_q <= fin_status;
      end
    end
  end

  assign req_ready   = (state == IDLE) && !rst;
  assign resp_valid  = (state == RESP);
  assign resp_data   = rdata_q;
  assign resp_status = status_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = 4'hf;
  assign wbm_we_o    = we_q;
  assign wbm_cyc_o   = (state == BUS);
  assign wbm_stb_o   = (state == BUS);
  assign wbm_cti_o   = 3'b000;
  assign wbm_bte_o   = 2'b00;

endmodule

// File: tb/tb_na_conf_wbm.sv
// tb_na_conf_wbm: table + random checks of na_conf_wbm.
// Watchdog section runs when NA_CONF_WBM_TIMEOUT_EN is defined.
module tb_na_conf_wbm;

  localparam logic [31:0] BASE = 32'hABCD_0000;
  localparam int          MR   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_status;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        wbm_rty_i;
  logic [31:0] wbm_dat_i;

  int checks   = 0;
  int failures = 0;

  na_conf_wbm #(
    .BASE_ADDR(BASE),
    .MAX_RETRY(MR),
    .TIMEOUT  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_status(resp_status),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_cti_o  (wbm_cti_o),
    .wbm_bte_o  (wbm_bte_o),
    .wbm_ack_i  (wbm_ack_i),
    .wbm_err_i  (wbm_err_i),
    .wbm_rty_i  (wbm_rty_i),
    .wbm_dat_i  (wbm_dat_i)
  );

  always #5 clk = ~clk;

  // term codes: 0 ack, 1 err, 2 rty, 3 err+ack, 4 ack+rty
  typedef struct {
    logic             we;
    logic [15:0]      addr;
    logic [31:0]      data;
    logic [31:0]      rdata;
    logic [3:0][3:0]  w;
    logic [3:0][2:0]  t;
    int               hold;
    logic [1:0]       st;
    logic [31:0]      d;
    int               cyc;
    int               att;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic junk_terms();
    wbm_ack_i = 1'($urandom);
    wbm_err_i = 1'($urandom);
    wbm_rty_i = 1'($urandom);
    wbm_dat_i = $urandom;
  endtask

  task automatic quiet_terms();
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    wbm_dat_i = $urandom;
  endtask

  function automatic logic [3:0][3:0] mk_w(input int a, b, c, d);
    mk_w = {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [3:0][2:0] mk_t(input int a, b, c, d);
    mk_t = {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Reference: walk the slave's answers attempt by attempt.
  function automatic void model(input logic we, input logic [31:0] rdata,
                                input logic [3:0][3:0] w,
                                input logic [3:0][2:0] t,
                                output logic [1:0] st,
                                output logic [31:0] d,
                                output int cyc, output int att);
    st  = 2'b00;
    d   = 32'h0;
    cyc = 0;
    att = 0;
    for (int i = 0; i <= MR; i++) begin
      att++;
      cyc += int'(w[i]) + 1;
      if (t[i] == 3'd1 || t[i] == 3'd3) begin
        st = 2'b01;
        return;
      end
      if (t[i] == 3'd0 || t[i] == 3'd4) begin
        d = we ? 32'h0 : rdata;
        return;
      end
      if (i == MR) begin
        st = 2'b10;
        return;
      end
      cyc += 1;
    end
  endfunction

  task automatic do_txn(input vec_t v);
    int          ncyc;
    int          att;
    int          wc;
    int          idx;
    logic        prev;
    logic [31:0] eadr;
    logic [31:0] edat;
    logic [31:0] hd;
    logic [1:0]  hs;
    eadr = {BASE[31:16], v.addr[15:2], 2'b00};
    edat = v.we ? v.data : 32'h0;
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_data  = v.data;
    junk_terms();
    tick();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_data  = $urandom;
    ncyc = 0;
    att  = 0;
    wc   = 0;
    prev = 1'b0;
    while (!resp_valid) begin
      if (ncyc >= 200) begin
        chk("resp_timeout", 128'(ncyc), 128'(v.cyc));
        break;
      end
      if (wbm_cyc_o) begin
        if (!prev) begin
          att++;
          wc = 0;
        end
        chk("bus_sig",
            {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o,
             wbm_sel_o, wbm_cti_o, wbm_bte_o},
            {eadr, edat, v.we, 1'b1, 4'hf, 3'b000, 2'b00});
        idx = (att > 4) ? 3 : att - 1;
        if (wc == int'(v.w[idx])) begin
          wbm_ack_i = v.t[idx] inside {3'd0, 3'd3, 3'd4};
          wbm_err_i = v.t[idx] inside {3'd1, 3'd3};
          wbm_rty_i = v.t[idx] inside {3'd2, 3'd4};
          wbm_dat_i = v.rdata;
        end else begin
          quiet_terms();
        end
        wc++;
      end else begin
        chk("req_ready_busy", 128'(req_ready), 128'(0));
        junk_terms();
      end
      prev = wbm_cyc_o;
      tick();
      ncyc++;
    end
    chk("latency", 128'(ncyc), 128'(v.cyc));
    chk("attempts", 128'(att), 128'(v.att));
    chk("resp", {resp_status, resp_data}, {v.st, v.d});
    hd = resp_data;
    hs = resp_status;
    resp_ready = 1'b0;
    for (int i = 0; i < v.hold; i++) begin
      junk_terms();
      tick();
      chk("hold", {resp_valid, req_ready, wbm_cyc_o, resp_status, resp_data},
          {1'b1, 1'b0, 1'b0, hs, hd});
    end
    resp_ready = 1'b1;
    junk_terms();
    tick();
    resp_ready = 1'b0;
    chk("after_hs", {resp_valid, req_ready, wbm_cyc_o}, {1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    vec_t v;
    int   k;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    quiet_terms();

    tbl[0] = '{1'b0, 16'h0004, 32'h0, 32'hDEAD_BEEF, mk_w(0, 0, 0, 0),
               mk_t(0, 0, 0, 0), 2, 2'b00, 32'hDEAD_BEEF, 1, 1};
    tbl[1] = '{1'b1, 16'h0010, 32'h1234_5678, 32'hFFFF_FFFF,
               mk_w(3, 0, 0, 0), mk_t(0, 0, 0, 0), 1, 2'b00, 32'h0, 4, 1};
    tbl[2] = '{1'b0, 16'h0008, 32'h0, 32'h0000_55AA, mk_w(0, 0, 0, 0),
               mk_t(2, 2, 0, 0), 0, 2'b00, 32'h0000_55AA, 5, 3};
    tbl[3] = '{1'b1, 16'h0020, 32'hA5A5_A5A5, 32'h0000_1111,
               mk_w(0, 0, 0, 0), mk_t(2, 2, 2, 2), 0, 2'b10, 32'h0, 5, 3};
    tbl[4] = '{1'b0, 16'h000C, 32'h0, 32'h0000_0077, mk_w(1, 0, 0, 0),
               mk_t(3, 0, 0, 0), 10, 2'b01, 32'h0, 2, 1};
    tbl[5] = '{1'b0, 16'hFFFF, 32'h0, 32'hCAFE_F00D, mk_w(2, 1, 0, 0),
               mk_t(2, 0, 0, 0), 0, 2'b00, 32'hCAFE_F00D, 6, 2};
    tbl[6] = '{1'b1, 16'h0030, 32'h0000_0001, 32'h0000_0002,
               mk_w(0, 0, 0, 0), mk_t(2, 1, 0, 0), 0, 2'b01, 32'h0, 3, 2};
    tbl[7] = '{1'b0, 16'h0040, 32'h0, 32'h0000_0001, mk_w(0, 0, 0, 0),
               mk_t(4, 0, 0, 0), 0, 2'b00, 32'h0000_0001, 1, 1};

    tick();
    chk("reset_state",
        {req_ready, resp_valid, resp_status, resp_data, wbm_cyc_o,
         wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o},
        {1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    tick();
    rst = 1'b0;
    tick();
    chk("ready_after_reset", 128'(req_ready), 128'(1));

    for (int i = 0; i < 8; i++) do_txn(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.we    = 1'($urandom);
      v.addr  = 16'($urandom);
      v.data  = $urandom;
      v.rdata = $urandom;
      v.w     = mk_w($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
      v.t     = mk_t($urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4));
      v.hold  = $urandom_range(0, 3);
      model(v.we, v.rdata, v.w, v.t, v.st, v.d, v.cyc, v.att);
      do_txn(v);
    end

`ifdef NA_CONF_WBM_TIMEOUT_EN
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 16'h0050;
    tick();
    req_valid = 1'b0;
    quiet_terms();
    k = 0;
    while (!resp_valid && k < 100) begin
      if (wbm_cyc_o) k++;
      tick();
    end
    chk("wd_cycles", 128'(k), 128'(8));
    chk("wd_resp", {resp_valid, resp_status, resp_data},
        {1'b1, 2'b11, 32'h0});
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    k = 3;
`else
    k = 20;
`endif

    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0060;
    req_data  = 32'h0BAD_F00D;
    tick();
    req_valid = 1'b0;
    quiet_terms();
    repeat (k) tick();
    chk("silent_bus", {wbm_cyc_o, resp_valid}, {1'b1, 1'b0});
    rst = 1'b1;
    tick();
    chk("rst_drop", {wbm_cyc_o, wbm_stb_o, resp_valid}, {3'b000});
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      junk_terms();
      tick();
      chk("no_resp", {resp_valid, wbm_cyc_o, req_ready}, {3'b001});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
